// File: rtl/rtl_settings_pkg.sv
// rtl_settings_pkg: shared widths, descriptor types and checker helper functions
//    ADDR_W/ADDR_B_W/DATA_B_W/AMM_DATA_W/AMM_BURST_W : datapath widths
//    cmp_struct_t : read/write command descriptor from the transaction generator
//    burst_t      : reduced descriptor kept in the checker FIFO
package rtl_settings_pkg;

   localparam int ADDR_W      = 32;
   localparam int DATA_B_W    = 64;
   localparam int ADDR_B_W    = 6;
   localparam int AMM_DATA_W  = DATA_B_W * 8;
   localparam int AMM_BURST_W = 4;

   localparam logic [7:0] LFSR_SEED_SUB = 8'hFF;

   typedef enum logic {FIX_DATA = 1'b0, RND_DATA = 1'b1} data_mode_t;
   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} chk_state_t;

   typedef struct packed {
      logic                   trans_type;
      data_mode_t             data_mode;
      logic [7:0]             data_ptrn;
      logic [ADDR_W-1:0]      start_addr;
      logic [AMM_BURST_W-1:0] words_count;
      logic [ADDR_B_W-1:0]    start_off;
      logic [ADDR_B_W-1:0]    end_off;
   } cmp_struct_t;

   typedef struct packed {
      data_mode_t                 data_mode;
      logic [7:0]                 data_ptrn;
      logic [ADDR_W-ADDR_B_W-1:0] base;
      logic [AMM_BURST_W-1:0]     words_count;
      logic [ADDR_B_W-1:0]        start_off;
      logic [ADDR_B_W-1:0]        end_off;
   } burst_t;

   // Fibonacci LFSR, taps 8,6,5,4
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic logic [DATA_B_W-1:0] byteenable_ptrn(input logic first, input logic last,
                                                           input logic [ADDR_B_W-1:0] start_off,
                                                           input logic [ADDR_B_W-1:0] end_off);
      logic [DATA_B_W-1:0] m;
      for (int i = 0; i < DATA_B_W; i++)
         m[i] = (!first || ADDR_B_W'(i) >= start_off) && (!last || ADDR_B_W'(i) <= end_off);
      return m;
   endfunction

   function automatic logic [DATA_B_W-1:0] check_vector(input logic [AMM_DATA_W-1:0] data,
                                                        input logic [7:0] exp_byte,
                                                        input logic [DATA_B_W-1:0] mask);
      logic [DATA_B_W-1:0] v;
      for (int i = 0; i < DATA_B_W; i++)
         v[i] = mask[i] && (data[8*i +: 8] != exp_byte);
      return v;
   endfunction

   // index of the lowest mismatching byte
   function automatic logic [ADDR_B_W-1:0] err_byte(input logic [DATA_B_W-1:0] vec);
      logic [ADDR_B_W-1:0] idx;
      idx = '0;
      for (int i = DATA_B_W - 1; i >= 0; i--)
         if (vec[i]) idx = ADDR_B_W'(i);
      return idx;
   endfunction

endpackage

// File: rtl/read_data_checker_cmd_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO with registered full/empty
//    clk_i, rst_n_i (sync active-low), clr_i : clock, reset, flush
//    push_i/data_i : write side; pop_i/data_o : read side, data_o shows the head
//    full_o, empty_o : registered status flags
module cmd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_full, r_empty, w_push, w_pop;

   // a pop in the same cycle frees the slot for a push on a full FIFO
   assign w_pop     = pop_i && !r_empty;
   assign w_push    = push_i && (!r_full || w_pop);
   assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
   assign data_o    = r_mem[r_rd];
   assign full_o    = r_full;
   assign empty_o   = r_empty;

   always_ff @(posedge clk_i)
      if (w_push) r_mem[r_wr] <= data_i;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr_i) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_cnt   <= w_cnt_nxt;
         r_full  <= w_cnt_nxt == CW'(DEPTH);
         r_empty <= w_cnt_nxt == '0;
      end
   end

endmodule

// File: rtl/read_data_checker.sv
// read_data_checker: compares AMM read beats against descriptor-derived expected bytes
//    clk_i, rst_n_i (sync active-low), clr_i : clock, reset, test start
//    cmp_struct_i/cmp_valid_i/cmp_ready_o  : issued-burst descriptors
//    readdatavalid_i/readdata_i            : AMM read return beats
//    busy_o, err_o, err_addr_o, err_data_o, err_exp_o, err_cnt_o, proto_err_o : status
module read_data_checker
   import rtl_settings_pkg::*;
#(
   parameter int CMD_FIFO_DEPTH = 8,
   parameter int ERR_CNT_W      = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         clr_i,
   input  logic [$bits(cmp_struct_t)-1:0] cmp_struct_i,
   input  logic                         cmp_valid_i,
   output logic                         cmp_ready_o,
   input  logic                         readdatavalid_i,
   input  logic [AMM_DATA_W-1:0]        readdata_i,
   output logic                         busy_o,
   output logic                         err_o,
   output logic [ADDR_W-1:0]            err_addr_o,
   output logic [7:0]                   err_data_o,
   output logic [7:0]                   err_exp_o,
   output logic [ERR_CNT_W-1:0]         err_cnt_o,
   output logic                         proto_err_o
);

   cmp_struct_t            w_cmd;
   burst_t                 w_new, w_head, r_act;
   logic [$bits(burst_t)-1:0] w_head_raw;
   logic                   w_full, w_empty, w_push, w_pop, w_beat, w_last, w_hit;
   logic                   w_unused_addr_lsb;
   chk_state_t             r_state;
   logic [AMM_BURST_W-1:0] r_beat;
   logic [7:0]             r_lfsr;
   logic                   r_proto_err;
   logic                   r_s1_valid;
   logic [AMM_DATA_W-1:0]  r_s1_data;
   logic [DATA_B_W-1:0]    r_s1_mask, w_mask, w_vec;
   logic [7:0]             r_s1_exp, w_exp;
   logic [ADDR_W-1:0]      r_s1_addr, w_beat_addr;
   logic [ADDR_B_W-1:0]    w_eb;
   logic                   r_err;
   logic [ADDR_W-1:0]      r_err_addr;
   logic [7:0]             r_err_data, r_err_exp;
   logic [ERR_CNT_W-1:0]   r_err_cnt;

   assign w_cmd             = cmp_struct_t'(cmp_struct_i);
   assign w_unused_addr_lsb = ^w_cmd.start_addr[ADDR_B_W-1:0];
   assign w_new             = '{data_mode: w_cmd.data_mode, data_ptrn: w_cmd.data_ptrn,
                                base: w_cmd.start_addr[ADDR_W-1:ADDR_B_W], words_count: w_cmd.words_count,
                                start_off: w_cmd.start_off, end_off: w_cmd.end_off};
   // write descriptors carry no read data, so they are consumed without storage
   assign w_push            = cmp_valid_i && cmp_ready_o && !w_cmd.trans_type;
   assign cmp_ready_o       = !w_full;
   assign w_head            = burst_t'(w_head_raw);

   cmd_fifo #(.W($bits(burst_t)), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (clr_i),
      .push_i  (w_push),
      .data_i  (w_new),
      .pop_i   (w_pop),
      .data_o  (w_head_raw),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign w_beat = readdatavalid_i && r_state == BURST;
   assign w_last = r_beat == r_act.words_count;
   // popping on the last beat gives back-to-back bursts without a bubble
   assign w_pop  = !w_empty && (r_state == IDLE || (w_beat && w_last));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr_i) begin
         r_state     <= IDLE;
         r_act       <= '0;
         r_beat      <= '0;
         r_lfsr      <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_pop) begin
            r_state <= BURST;
            r_act   <= w_head;
            r_beat  <= '0;
            r_lfsr  <= w_head.data_ptrn == 8'h00 ? LFSR_SEED_SUB : w_head.data_ptrn;
         end else if (w_beat) begin
            if (w_last) r_state <= IDLE;
            else begin
               r_beat <= r_beat + AMM_BURST_W'(1);
               r_lfsr <= lfsr_step(r_lfsr);
            end
         end
         if (readdatavalid_i && r_state == IDLE && w_empty) r_proto_err <= 1'b1;
      end
   end

   assign w_mask      = byteenable_ptrn(r_beat == '0, w_last, r_act.start_off, r_act.end_off);
   assign w_exp       = r_act.data_mode == RND_DATA ? r_lfsr : r_act.data_ptrn;
   assign w_beat_addr = {r_act.base, {ADDR_B_W{1'b0}}} + (ADDR_W'(r_beat) << ADDR_B_W);
   assign w_vec       = check_vector(r_s1_data, r_s1_exp, r_s1_mask);
   assign w_eb        = err_byte(w_vec);
   assign w_hit       = r_s1_valid && |w_vec;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr_i) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_mask  <= '0;
         r_s1_exp   <= '0;
         r_s1_addr  <= '0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
         r_err_data <= '0;
         r_err_exp  <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_s1_valid <= w_beat;
         r_s1_data  <= readdata_i;
         r_s1_mask  <= w_mask;
         r_s1_exp   <= w_exp;
         r_s1_addr  <= w_beat_addr;
         if (w_hit) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            if (!r_err) begin
               r_err      <= 1'b1;
               r_err_addr <= r_s1_addr + ADDR_W'(w_eb);
               r_err_data <= r_s1_data[8*w_eb +: 8];
               r_err_exp  <= r_s1_exp;
            end
         end
      end
   end

   assign busy_o      = !w_empty || r_state == BURST || r_s1_valid;
   assign err_o       = r_err;
   assign err_addr_o  = r_err_addr;
   assign err_data_o  = r_err_data;
   assign err_exp_o   = r_err_exp;
   assign err_cnt_o   = r_err_cnt;
   assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_read_data_checker.sv
// tb_read_data_checker: directed self-checking bench for read_data_checker
module tb_read_data_checker;
   import rtl_settings_pkg::*;

   logic                           clk = 1'b0;
   logic                           rst_n = 1'b0;
   logic                           clr = 1'b0;
   logic [$bits(cmp_struct_t)-1:0] cmp_struct = '0;
   logic                           cmp_valid = 1'b0;
   logic                           cmp_ready;
   logic                           rdv = 1'b0;
   logic [AMM_DATA_W-1:0]          rdata = '0;
   logic                           busy, err, proto_err;
   logic [ADDR_W-1:0]              err_addr;
   logic [7:0]                     err_data, err_exp;
   logic [31:0]                    err_cnt;
   int                             checks = 0;
   int                             errors = 0;

   read_data_checker dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .clr_i           (clr),
      .cmp_struct_i    (cmp_struct),
      .cmp_valid_i     (cmp_valid),
      .cmp_ready_o     (cmp_ready),
      .readdatavalid_i (rdv),
      .readdata_i      (rdata),
      .busy_o          (busy),
      .err_o           (err),
      .err_addr_o      (err_addr),
      .err_data_o      (err_data),
      .err_exp_o       (err_exp),
      .err_cnt_o       (err_cnt),
      .proto_err_o     (proto_err)
   );

   always #5 clk = ~clk;

   function automatic cmp_struct_t mk(input logic tt, input data_mode_t m, input logic [7:0] p,
                                      input logic [31:0] a, input logic [3:0] wc,
                                      input logic [5:0] so, input logic [5:0] eo);
      return '{trans_type: tt, data_mode: m, data_ptrn: p, start_addr: a, words_count: wc,
               start_off: so, end_off: eo};
   endfunction

   function automatic logic [AMM_DATA_W-1:0] fill(input logic [7:0] b);
      return {DATA_B_W{b}};
   endfunction

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input cmp_struct_t d);
      cmp_struct = d;
      cmp_valid  = 1'b1;
      cyc;
      cmp_valid  = 1'b0;
   endtask

   task automatic beat(input logic [AMM_DATA_W-1:0] d);
      rdv   = 1'b1;
      rdata = d;
      cyc;
      rdv   = 1'b0;
   endtask

   task automatic do_clr;
      clr = 1'b1;
      cyc;
      clr = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      cyc;
      cyc;
      rst_n = 1'b1;
      cyc;
      checks++; if (cmp_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0h exp 1", cmp_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h exp 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0h exp 0", err); end
      checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0h exp 0", err_cnt); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto: got %0h exp 0", proto_err); end
      checks++; if (err_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %0h exp 0", err_addr); end
   endtask

   task automatic test_fix_data;
      logic [AMM_DATA_W-1:0] d;
      push(mk(1'b0, FIX_DATA, 8'hA5, 32'h100, 4'd0, 6'd3, 6'd60));
      cyc;
      beat(fill(8'hA5));
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fix_busy_pipe: got %0h exp 1", busy); end
      cyc;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fix_busy_fall: got %0h exp 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL fix_clean_err: got %0h exp 0", err); end
      checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL fix_clean_cnt: got %0h exp 0", err_cnt); end
      d = fill(8'hA5);
      d[8*2 +: 8]  = 8'h00;
      d[8*61 +: 8] = 8'h00;
      push(mk(1'b0, FIX_DATA, 8'hA5, 32'h100, 4'd0, 6'd3, 6'd60));
      cyc;
      beat(d);
      cyc;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL fix_masked_err: got %0h exp 0", err); end
      checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL fix_masked_cnt: got %0h exp 0", err_cnt); end
      d = fill(8'hA5);
      d[8*5 +: 8] = 8'h00;
      push(mk(1'b0, FIX_DATA, 8'hA5, 32'h100, 4'd0, 6'd3, 6'd60));
      cyc;
      beat(d);
      cyc;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL fix_hit_err: got %0h exp 1", err); end
      checks++; if (err_addr !== 32'h105) begin errors++; $display("FAIL fix_hit_addr: got %0h exp 105", err_addr); end
      checks++; if (err_data !== 8'h00) begin errors++; $display("FAIL fix_hit_data: got %0h exp 00", err_data); end
      checks++; if (err_exp !== 8'hA5) begin errors++; $display("FAIL fix_hit_exp: got %0h exp a5", err_exp); end
      checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL fix_hit_cnt: got %0h exp 1", err_cnt); end
      d = fill(8'hA5);
      d[8*60 +: 8] = 8'h11;
      push(mk(1'b0, FIX_DATA, 8'hA5, 32'h100, 4'd0, 6'd3, 6'd60));
      cyc;
      beat(d);
      cyc;
      checks++; if (err_cnt !== 32'd2) begin errors++; $display("FAIL fix_endoff_cnt: got %0h exp 2", err_cnt); end
      checks++; if (err_addr !== 32'h105) begin errors++; $display("FAIL fix_keep_addr: got %0h exp 105", err_addr); end
   endtask

   task automatic test_burst_mask;
      logic [AMM_DATA_W-1:0] d;
      do_clr;
      push(mk(1'b0, FIX_DATA, 8'h3C, 32'h207, 4'd2, 6'd10, 6'd5));
      cyc;
      d = fill(8'h3C);
      d[7:0] = 8'h00;
      beat(d);
      beat(d);
      d = fill(8'h3C);
      d[8*63 +: 8] = 8'h00;
      beat(d);
      cyc;
      checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL mask_cnt: got %0h exp 1", err_cnt); end
      checks++; if (err_addr !== 32'h240) begin errors++; $display("FAIL mask_addr: got %0h exp 240", err_addr); end
      checks++; if (err_exp !== 8'h3C) begin errors++; $display("FAIL mask_exp: got %0h exp 3c", err_exp); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mask_busy: got %0h exp 0", busy); end
   endtask

   task automatic test_rnd_data;
      logic [AMM_DATA_W-1:0] d;
      do_clr;
      push(mk(1'b0, RND_DATA, 8'h01, 32'h1000, 4'd3, 6'd0, 6'd63));
      cyc;
      beat(fill(8'h01));
      beat(fill(8'h02));
      d = fill(8'h04);
      d[8*10 +: 8] = 8'hEE;
      beat(d);
      d = fill(8'h08);
      d[7:0] = 8'h77;
      beat(d);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL rnd_err: got %0h exp 1", err); end
      checks++; if (err_addr !== 32'h108A) begin errors++; $display("FAIL rnd_addr: got %0h exp 108a", err_addr); end
      checks++; if (err_data !== 8'hEE) begin errors++; $display("FAIL rnd_data: got %0h exp ee", err_data); end
      checks++; if (err_exp !== 8'h04) begin errors++; $display("FAIL rnd_exp: got %0h exp 04", err_exp); end
      checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL rnd_cnt1: got %0h exp 1", err_cnt); end
      cyc;
      checks++; if (err_cnt !== 32'd2) begin errors++; $display("FAIL rnd_cnt2: got %0h exp 2", err_cnt); end
      checks++; if (err_addr !== 32'h108A) begin errors++; $display("FAIL rnd_keep_addr: got %0h exp 108a", err_addr); end
      checks++; if (err_exp !== 8'h04) begin errors++; $display("FAIL rnd_keep_exp: got %0h exp 04", err_exp); end
      push(mk(1'b0, RND_DATA, 8'h00, 32'h1100, 4'd1, 6'd0, 6'd63));
      cyc;
      beat(fill(8'hFF));
      beat(fill(8'hFE));
      cyc;
      checks++; if (err_cnt !== 32'd2) begin errors++; $display("FAIL rnd_seed0_cnt: got %0h exp 2", err_cnt); end
   endtask

   task automatic test_back_to_back;
      do_clr;
      for (int k = 0; k < 9; k++)
         push(mk(1'b0, FIX_DATA, 8'(16 + k), 32'h2000 + 32'(k * 64), 4'd0, 6'd0, 6'd63));
      checks++; if (cmp_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0h exp 0", cmp_ready); end
      push(mk(1'b0, FIX_DATA, 8'h99, 32'h3000, 4'd0, 6'd0, 6'd63));
      checks++; if (cmp_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_full: got %0h exp 0", cmp_ready); end
      for (int k = 0; k < 9; k++)
         beat(fill(8'(16 + k)));
      cyc;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %0h exp 0", err); end
      checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL b2b_cnt: got %0h exp 0", err_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %0h exp 0", busy); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_proto: got %0h exp 0", proto_err); end
      checks++; if (cmp_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0h exp 1", cmp_ready); end
   endtask

   task automatic test_proto;
      do_clr;
      beat(fill(8'h12));
      cyc;
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %0h exp 1", proto_err); end
      checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL proto_cnt: got %0h exp 0", err_cnt); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL proto_err_flag: got %0h exp 0", err); end
      push(mk(1'b1, FIX_DATA, 8'h5A, 32'h400, 4'd0, 6'd0, 6'd63));
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy0: got %0h exp 0", busy); end
      cyc;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy1: got %0h exp 0", busy); end
   endtask

   task automatic check_cleared(input string tag);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s_err: got %0h exp 0", tag, err); end
      checks++; if (err_addr !== 32'd0) begin errors++; $display("FAIL %s_addr: got %0h exp 0", tag, err_addr); end
      checks++; if (err_data !== 8'd0) begin errors++; $display("FAIL %s_data: got %0h exp 0", tag, err_data); end
      checks++; if (err_exp !== 8'd0) begin errors++; $display("FAIL %s_exp: got %0h exp 0", tag, err_exp); end
      checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL %s_cnt: got %0h exp 0", tag, err_cnt); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL %s_proto: got %0h exp 0", tag, proto_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %0h exp 0", tag, busy); end
      checks++; if (cmp_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %0h exp 1", tag, cmp_ready); end
      beat(fill(8'h55));
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL %s_idle_proto: got %0h exp 1", tag, proto_err); end
   endtask

   task automatic test_clear;
      do_clr;
      push(mk(1'b0, FIX_DATA, 8'h55, 32'h3000, 4'd3, 6'd0, 6'd63));
      cyc;
      beat(fill(8'h00));
      cyc;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_pre_err: got %0h exp 1", err); end
      checks++; if (err_addr !== 32'h3000) begin errors++; $display("FAIL clr_pre_addr: got %0h exp 3000", err_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy: got %0h exp 1", busy); end
      cmp_struct = mk(1'b0, FIX_DATA, 8'h55, 32'h3100, 4'd0, 6'd0, 6'd63);
      cmp_valid  = 1'b1;
      rdv        = 1'b1;
      rdata      = fill(8'h00);
      clr        = 1'b1;
      cyc;
      clr        = 1'b0;
      cmp_valid  = 1'b0;
      rdv        = 1'b0;
      check_cleared("clr");
      do_clr;
      push(mk(1'b0, FIX_DATA, 8'h55, 32'h3000, 4'd3, 6'd0, 6'd63));
      cyc;
      beat(fill(8'h00));
      cyc;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL rstm_pre_err: got %0h exp 1", err); end
      rst_n = 1'b0;
      cyc;
      rst_n = 1'b1;
      check_cleared("rstm");
   endtask

   initial begin
      test_reset;
      test_fix_data;
      test_burst_mask;
      test_rnd_data;
      test_back_to_back;
      test_proto;
      test_clear;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
